// File: rtl/bus_xfer_sequencer.sv
// Bus transfer sequencer: turns one {source, destination, hold} command into
// timed one-hot source out-enables and destination load-enables, with at most
// one source driving the bus in any cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// DRIVE | source drives the bus; counter counts down the settle cycles
// LATCH | source still drives; destination load-enable high one cycle
module bus_xfer_sequencer #(
  parameter int NSRC = 24,
  parameter int NDST = 24,
  parameter int CW   = 5
) (
  input  logic            clock_i,
  input  logic            clear_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [CW-1:0]   cmd_src_i,
  input  logic [CW-1:0]   cmd_dst_i,
  input  logic [1:0]      cmd_hold_i,
  output logic [NSRC-1:0] src_oe_o,
  output logic [NDST-1:0] dst_le_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Code limits widened by one bit so a code equal to NSRC/NDST compares correctly.
  localparam logic [CW:0] SRC_LIM = (CW+1)'(NSRC);
  localparam logic [CW:0] DST_LIM = (CW+1)'(NDST);
  localparam logic [NSRC-1:0] SRC_ONE = {{(NSRC-1){1'b0}}, 1'b1};
  localparam logic [NDST-1:0] DST_ONE = {{(NDST-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CW-1:0]   dst_q, dst_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NSRC-1:0] src_oe_q, src_oe_d;
  logic [NDST-1:0] dst_le_q, dst_le_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic accept;
  logic codes_ok;

  assign accept   = cmd_valid_i && (state_q == IDLE);
  assign codes_ok = ({1'b0, cmd_src_i} < SRC_LIM) && ({1'b0, cmd_dst_i} < DST_LIM);

  assign cmd_ready_o = (state_q == IDLE);
  assign src_oe_o    = src_oe_q;
  assign dst_le_o    = dst_le_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Next-state and next-output decode; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    src_oe_d = '0;
    dst_le_d = '0;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (codes_ok) begin
            state_d  = DRIVE;
            dst_d    = cmd_dst_i;
            cnt_d    = cmd_hold_i;
            src_oe_d = SRC_ONE << cmd_src_i;
          end else begin
            // Bad code: retire immediately without touching the bus.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      DRIVE: begin
        src_oe_d = src_oe_q;
        if (cnt_q == 2'd0) begin
          state_d  = LATCH;
          dst_le_d = DST_ONE << dst_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      LATCH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, captured command and registered outputs; clear drops every enable at once.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q  <= IDLE;
      dst_q    <= '0;
      cnt_q    <= 2'd0;
      src_oe_q <= '0;
      dst_le_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      src_oe_q <= src_oe_d;
      dst_le_q <= dst_le_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
